// File: rtl/load_scoreboard_pkg.sv
// Shared constants and helpers for the load scoreboard.
// Holds the architectural register count, the register address width and the
// default pending-load counter width, plus the per-cycle counter operation
// decode used by every per-register counter.
package load_scoreboard_pkg;

  localparam int LDSB_NUM_REGS  = 32;
  localparam int LDSB_ADDR_W    = 5;
  localparam int LDSB_CNT_W_DEF = 2;

  // What a single register's pending-load counter does this cycle.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2,
    CNT_CLR  = 2'd3
  } cnt_op_e;

  // Flush wins over everything; an issue and a commit to the same register in
  // the same cycle cancel out.
  function automatic cnt_op_e cnt_op(input logic flush, input logic inc, input logic dec);
    if (flush)
      return CNT_CLR;
    if (inc && !dec)
      return CNT_INC;
    if (dec && !inc)
      return CNT_DEC;
    return CNT_HOLD;
  endfunction

endpackage

// File: rtl/ldsb_cnt.sv
// Per-register pending-load counter for the load scoreboard.
// Saturating up/down counter: increments when a load to this register leaves
// EX, decrements when WB commits it. Incrementing a full counter or
// decrementing an empty one leaves the value unchanged and raises err for
// one cycle so the top can latch a sticky error.
module ldsb_cnt
  import load_scoreboard_pkg::*;
#(
  parameter int CNT_W = LDSB_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             nz_nxt,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  // Next counter value and the over/underflow indication for this cycle.
  always_comb begin
    cnt_nxt = cnt;
    err     = 1'b0;
    case (cnt_op(flush, inc, dec))
      CNT_CLR: cnt_nxt = '0;
      CNT_INC: begin
        cnt_nxt = sat_inc(cnt);
        err     = (cnt == CNT_MAX);
      end
      CNT_DEC: begin
        cnt_nxt = sat_dec(cnt);
        err     = (cnt == '0);
      end
      default: cnt_nxt = cnt;
    endcase
  end

  assign nz_nxt = |cnt_nxt;

  // Counter state; reset discards any pending loads.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

endmodule

// File: rtl/load_scoreboard.sv
// Load-use scoreboard: tracks outstanding loads per architectural register and
// holds decode while a source operand still waits on a load result.
// Register 0 is hardwired and never tracked. There is no WB bypass: a register
// keeps stalling in the cycle its last load commits and releases one cycle later.
// Optional feature: define LDSB_PERF_CNT_EN to build the saturating stall-cycle
// counter on sb_stall_cnt; otherwise sb_stall_cnt is tied to zero.
module load_scoreboard
  import load_scoreboard_pkg::*;
#(
  parameter int CNT_W = LDSB_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   ds_valid,
  input  logic [LDSB_ADDR_W-1:0] ds_rf_raddr1,
  input  logic [LDSB_ADDR_W-1:0] ds_rf_raddr2,
  input  logic                   es_issue,
  input  logic [LDSB_ADDR_W-1:0] es_dest,
  input  logic                   ws_load_we,
  input  logic [LDSB_ADDR_W-1:0] ws_dest,
  input  logic                   flush,
  output logic                   sb_stall,
  output logic                   sb_issue_ready,
  output logic                   sb_busy,
  output logic                   sb_err,
  output logic [31:0]            sb_stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LDSB_NUM_REGS-1:0][CNT_W-1:0] cnt_all;
  logic [LDSB_NUM_REGS-1:1]            nz_nxt_v;
  logic [LDSB_NUM_REGS-1:1]            err_v;
  logic                                hit1;
  logic                                hit2;

  // Register 0 has no counter; reading it as zero keeps every lookup in range.
  assign cnt_all[0] = '0;

  for (genvar r = 1; r < LDSB_NUM_REGS; r++) begin : g_reg
    ldsb_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk    (clk),
      .resetn (resetn),
      .flush  (flush),
      .inc    (es_issue   && (es_dest == LDSB_ADDR_W'(r))),
      .dec    (ws_load_we && (ws_dest == LDSB_ADDR_W'(r))),
      .cnt    (cnt_all[r]),
      .nz_nxt (nz_nxt_v[r]),
      .err    (err_v[r])
    );
  end

  // A source hits when its load is pending or is leaving EX right now.
  always_comb begin
    hit1 = (ds_rf_raddr1 != '0) &&
           ((cnt_all[ds_rf_raddr1] != '0) || (es_issue && (es_dest == ds_rf_raddr1)));
    hit2 = (ds_rf_raddr2 != '0) &&
           ((cnt_all[ds_rf_raddr2] != '0) || (es_issue && (es_dest == ds_rf_raddr2)));
  end

  assign sb_stall       = ds_valid && (hit1 || hit2);
  assign sb_issue_ready = !((es_dest != '0) && (cnt_all[es_dest] == CNT_MAX));

  // Busy mirrors the counters as they will be after this edge; error is sticky
  // until reset and survives flush.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sb_busy <= 1'b0;
      sb_err  <= 1'b0;
    end else begin
      sb_busy <= |nz_nxt_v;
      sb_err  <= sb_err | (|err_v);
    end
  end

`ifdef LDSB_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Count decode stall cycles, holding at all-ones.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      stall_cnt_q <= 32'd0;
    else if (sb_stall)
      stall_cnt_q <= sat_inc32(stall_cnt_q);
  end

  assign sb_stall_cnt = stall_cnt_q;
`else
  assign sb_stall_cnt = 32'd0;
`endif

endmodule
